// File: rtl/dyn_node_arb_pkg.sv
// Shared definitions for the dynamic output arbiter: lock FSM encoding and
// default location of the header payload-length field.
package dyn_node_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_LEN_LSB = 22;
  localparam int DEF_LEN_W   = 8;

endpackage

// File: rtl/dyn_output_arb_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping modulo N.
// Zero latency; no state, so backpressure is the caller's concern.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/dyn_output_arb_mux.sv
// Packet-locking N:1 flit mux: round-robin on headers, holds the channel for len body flits.
// One registered stage, 1-cycle latency; inputs stall whenever the output register is full and not drained.
module dyn_output_arb_mux
  import dyn_node_arb_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_IN  = 5,
  parameter int LEN_LSB = DEF_LEN_LSB,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_sel
);

  localparam int IW = $clog2(NUM_IN);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] ch_dat [NUM_IN];
  logic [NUM_IN-1:0] gnt;
  logic [IW-1:0]    gnt_idx, sel_idx;
  logic             gnt_vld, load_en, load;
  logic [WIDTH-1:0] sel_dat;
  logic [LEN_W-1:0] hdr_len;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (int'(idx) == NUM_IN - 1) ? '0 : idx + IW'(1);
  endfunction

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    assign ch_dat[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(NUM_IN), .IW(IW)) u_rr (
    .req_i (in_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign load_en = !out_valid_q || out_ready;
  assign sel_idx = (state_q == LOCKED) ? owner_q : gnt_idx;
  assign sel_dat = ch_dat[sel_idx];
  assign hdr_len = sel_dat[LEN_LSB +: LEN_W];
  assign load    = |(in_valid & in_ready);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    rem_d    = rem_q;
    in_ready = '0;
    case (state_q)
      IDLE: begin
        if (load_en) in_ready = gnt;
        if (load_en && gnt_vld) begin
          if (hdr_len == '0) begin
            rr_ptr_d = wrap_inc(gnt_idx);
          end else begin
            state_d = LOCKED;
            owner_d = gnt_idx;
            rem_d   = hdr_len;
          end
        end
      end
      LOCKED: begin
        // Owner keeps the output across valid gaps until its last body flit.
        in_ready[owner_q] = load_en;
        if (load_en && in_valid[owner_q]) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
      end
      default: ;
    endcase
    if (!rst_n) in_ready = '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load_en) begin
      out_valid_d = load;
      if (load) out_data_d = sel_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = 3'(sel_idx);

endmodule

// File: tb/tb_dyn_output_arb_mux.sv
// Directed bench for dyn_output_arb_mux: header/lock behaviour, round-robin order,
// output stalls, maximum-length packets and mid-packet reset.
module tb_dyn_output_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [319:0] in_data;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_sel;

  int vecs = 0;
  int errs = 0;

  dyn_output_arb_mux #(.WIDTH(64), .NUM_IN(5), .LEN_LSB(22), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_hdr(input int ch, input int len, input int seq);
    return {8'(ch), 16'(seq), 10'h0, 8'(len), 22'h0};
  endfunction

  function automatic logic [63:0] mk_body(input int ch, input int seq);
    return {8'(ch), 16'(seq), 40'hBD00C00000};
  endfunction

  task automatic set_ch(input int ch, input logic [63:0] d);
    in_data[ch*64 +: 64] = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 5'b11111;
    in_data   = '0;
    for (int c = 0; c < 5; c++) set_ch(c, mk_hdr(c, 2, c));
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    chk("rst_hold_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    rst_n    = 1'b1;
    tick();

    // ch2 single-flit header
    in_valid = 5'b00100;
    set_ch(2, mk_hdr(2, 0, 1));
    #1;
    chk("a_in_ready", 64'(in_ready), 64'b00100);
    chk("a_sel", 64'(out_sel), 64'd2);
    tick();
    chk("a_out_valid", 64'(out_valid), 64'd1);
    chk("a_out_data", out_data, mk_hdr(2, 0, 1));
    in_valid = 5'b11111;
    for (int c = 0; c < 5; c++) set_ch(c, mk_hdr(c, 0, 16'h20 + c));
    #1;
    chk("a_rrptr_sel", 64'(out_sel), 64'd3);
    chk("a_rrptr_ready", 64'(in_ready), 64'b01000);
    in_valid = '0;
    tick();
    chk("a_drain_valid", 64'(out_valid), 64'd0);

    // move rr_ptr to 0, then all channels with single-flit packets
    in_valid = 5'b10000;
    tick();
    chk("c_pre_data", out_data, mk_hdr(4, 0, 16'h24));
    in_valid = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("c_order_sel", 64'(out_sel), 64'(k % 5));
      tick();
      chk("c_order_data", out_data, mk_hdr(k % 5, 0, 16'h20 + (k % 5)));
      chk("c_order_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 5'b10000;
    tick();
    chk("c_post_data", out_data, mk_hdr(4, 0, 16'h24));

    // ch0 len=3 packet while ch1 waits
    in_valid = 5'b00011;
    set_ch(0, mk_hdr(0, 3, 16'h30));
    set_ch(1, mk_hdr(1, 0, 16'h31));
    #1;
    chk("b_hdr_ready", 64'(in_ready), 64'b00001);
    tick();
    chk("b_hdr_data", out_data, mk_hdr(0, 3, 16'h30));
    for (int b = 1; b <= 3; b++) begin
      set_ch(0, mk_body(0, b));
      #1;
      chk("b_lock_ready", 64'(in_ready), 64'b00001);
      chk("b_lock_sel", 64'(out_sel), 64'd0);
      tick();
      chk("b_body_data", out_data, mk_body(0, b));
      chk("b_body_valid", 64'(out_valid), 64'd1);
    end
    set_ch(0, mk_hdr(0, 0, 16'h32));
    #1;
    chk("b_release_sel", 64'(out_sel), 64'd1);
    chk("b_release_ready", 64'(in_ready), 64'b00010);
    tick();
    chk("b_ch1_data", out_data, mk_hdr(1, 0, 16'h31));
    in_valid = '0;
    tick();

    // ch2 len=3 with a 4-cycle output stall and an owner bubble
    in_valid = 5'b01100;
    set_ch(2, mk_hdr(2, 3, 16'h40));
    set_ch(3, mk_hdr(3, 0, 16'h41));
    #1;
    chk("d_hdr_ready", 64'(in_ready), 64'b00100);
    tick();
    chk("d_hdr_data", out_data, mk_hdr(2, 3, 16'h40));
    set_ch(2, mk_body(2, 1));
    tick();
    chk("d_b1_data", out_data, mk_body(2, 1));
    set_ch(2, mk_body(2, 2));
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("d_stall_ready", 64'(in_ready), 64'd0);
      tick();
      chk("d_stall_data", out_data, mk_body(2, 1));
      chk("d_stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("d_resume_ready", 64'(in_ready), 64'b00100);
    tick();
    chk("d_b2_data", out_data, mk_body(2, 2));
    in_valid = 5'b01000;
    #1;
    chk("d_bubble_ready", 64'(in_ready), 64'b00100);
    chk("d_bubble_sel", 64'(out_sel), 64'd2);
    tick();
    chk("d_bubble_valid", 64'(out_valid), 64'd0);
    in_valid = 5'b01100;
    set_ch(2, mk_body(2, 3));
    tick();
    chk("d_b3_data", out_data, mk_body(2, 3));
    in_valid = 5'b01000;
    #1;
    chk("d_next_sel", 64'(out_sel), 64'd3);
    tick();
    chk("d_ch3_data", out_data, mk_hdr(3, 0, 16'h41));
    in_valid = '0;
    tick();

    // ch4 maximum-length packet, ch0 waiting
    in_valid = 5'b10001;
    set_ch(4, mk_hdr(4, 255, 16'h50));
    set_ch(0, mk_hdr(0, 0, 16'h51));
    #1;
    chk("e_hdr_ready", 64'(in_ready), 64'b10000);
    tick();
    chk("e_hdr_data", out_data, mk_hdr(4, 255, 16'h50));
    for (int i = 1; i <= 255; i++) begin
      set_ch(4, mk_body(4, i));
      #1;
      chk("e_lock_ready", 64'(in_ready), 64'b10000);
      tick();
      chk("e_body_data", out_data, mk_body(4, i));
    end
    set_ch(4, mk_hdr(4, 0, 16'h52));
    #1;
    chk("e_release_sel", 64'(out_sel), 64'd0);
    chk("e_release_ready", 64'(in_ready), 64'b00001);
    tick();
    chk("e_ch0_data", out_data, mk_hdr(0, 0, 16'h51));
    in_valid = '0;
    tick();

    // reset after 2 of 5 bodies
    in_valid = 5'b10000;
    set_ch(4, mk_hdr(4, 5, 16'h60));
    tick();
    chk("f_hdr_data", out_data, mk_hdr(4, 5, 16'h60));
    set_ch(4, mk_body(4, 1));
    tick();
    set_ch(4, mk_body(4, 2));
    tick();
    chk("f_b2_data", out_data, mk_body(4, 2));
    set_ch(4, mk_body(4, 3));
    rst_n = 1'b0;
    #1;
    chk("f_rst_valid", 64'(out_valid), 64'd0);
    chk("f_rst_data", out_data, 64'd0);
    chk("f_rst_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    set_ch(4, mk_hdr(4, 0, 16'h61));
    #1;
    chk("f_after_ready", 64'(in_ready), 64'b10000);
    tick();
    chk("f_after_data", out_data, mk_hdr(4, 0, 16'h61));
    in_valid = 5'b10010;
    set_ch(1, mk_hdr(1, 0, 16'h62));
    #1;
    chk("f_rearb_sel", 64'(out_sel), 64'd1);
    chk("f_rearb_ready", 64'(in_ready), 64'b00010);
    tick();
    chk("f_ch1_data", out_data, mk_hdr(1, 0, 16'h62));
    in_valid = '0;
    tick();
    chk("f_idle_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
